vr_apb_bridge: RTL and testbench
================================

# vr_apb_bridge

Converts the internal valid/ready request stream into APB completer transfers on the `*_hi` bus and returns a response with valid/ready semantics. The block sits directly upstream of the APB-facing top level. It consumes requests from the master-side stream and produces `psel_hi`, `penable_hi`, `paddr_hi` and `pwdata_hi`, and samples `prdata_hi`. One transfer is outstanding at a time. A response buffer and an access timeout are included.

## Interface
- `AW`, default 32: address width.
- `DW`, default 32: data width.
- `TIMEOUT`, default 16: maximum ACCESS cycles allowed without `pready_hi`. A value of 0 disables the timeout.

Ports:
- `i_clk`  in  1  clock; all state changes on the rising edge.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_valid`  in  1  request valid.
- `o_ready`  out  1  request accepted when `i_valid & o_ready`.
- `i_write`  in  1  1 = write, 0 = read.
- `i_addr`  in  AW  request address.
- `i_wdata`  in  DW  write data.
- `o_valid`  out  1  response valid.
- `i_ready`  in  1  response consumed when `o_valid & i_ready`.
- `o_data`  out  DW  read data; 0 for writes and errors.
- `o_resp`  out  2  response code: 00 OK, 01 MISALIGN, 10 SLVERR, 11 TIMEOUT.
- `psel_hi`  out  1  APB select.
- `penable_hi`  out  1  APB enable.
- `pwrite_hi`  out  1  APB direction.
- `paddr_hi`  out  AW  APB address.
- `pwdata_hi`  out  DW  APB write data.
- `prdata_hi`  in  DW  APB read data.
- `pready_hi`  in  1  APB ready.
- `pslverr_hi`  in  1  APB error.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE
  - `o_ready` = 1; all other outputs hold their reset values.
  - On handshake, capture `i_write`, `i_addr` and `i_wdata` into registers.
  - If `i_addr[1:0]` != 0: no APB transfer. Go to RESP with `o_resp` = 01 and `o_data` = 0.
  - Otherwise go to SETUP.
- SETUP
  - `psel_hi` = 1, `penable_hi` = 0.
  - `paddr_hi`, `pwrite_hi` and `pwdata_hi` are driven from the captured registers.
  - Unconditionally go to ACCESS.
- ACCESS
  - `psel_hi` = 1, `penable_hi` = 1. Address, direction and write data remain stable.
  - Timeout counter: cleared on entry, incremented each cycle `pready_hi` = 0.
  - On `pready_hi` = 1:
    - Capture `o_data` = read ? `prdata_hi` : 0.
    - Capture `o_resp` = `pslverr_hi` ? 10 : 00.
    - Go to RESP.
  - If `TIMEOUT` != 0 and the counter reaches `TIMEOUT` with `pready_hi` still 0: go to RESP with `o_resp` = 11 and `o_data` = 0.
  - `pready_hi` in the same cycle the counter reaches `TIMEOUT` takes priority: the transfer completes normally.
- RESP
  - `o_valid` = 1; `psel_hi` and `penable_hi` = 0.
  - `o_data` and `o_resp` are held until `i_ready`.
  - On handshake, go to IDLE.
- `o_ready` = 0 outside IDLE, so only one transfer is outstanding.
- Widths
  - Timeout counter is `$clog2(TIMEOUT+1)` bits and saturates; it never wraps.
  - `pslverr_hi` is ignored unless `pready_hi` = 1.
- Reset
  - All registers clear; state goes to IDLE.
  - Reset values: `psel_hi`, `penable_hi`, `pwrite_hi`, `o_valid` = 0; `paddr_hi`, `pwdata_hi`, `o_data`, `o_resp` = 0.
  - `o_ready` = 0 while `i_rst` = 1, and 1 in the first cycle after release.
- Reset mid-transfer: `psel_hi` and `penable_hi` fall at the reset edge. The pending request is discarded and no response is produced.

## Timing
- Request handshake at edge 0. SETUP in cycle 1, ACCESS in cycle 2.
- Zero-wait completer (`pready_hi` = 1 in cycle 2): `o_valid` is high in cycle 3.
- Each wait state adds one cycle.
- Misaligned request: `o_valid` is high in the cycle after the handshake.
- Maximum throughput: one transfer per 4 cycles, with `i_ready` tied high.
- The response is registered. `o_data` and `o_resp` are stable for the whole time `o_valid` is high.
- APB outputs are registered; no combinational path from `i_*` to `p*_hi`.
- Combinational paths:
  - `o_ready` depends only on state and `i_rst`.
  - `i_ready` and `pready_hi` affect registered state only.

## Test plan
- Zero-wait write.
  - Stimulus: `i_addr` = 0x1000_0004, `i_wdata` = 0xDEADBEEF, `pready_hi` tied 1.
  - Required: SETUP in cycle 1, ACCESS in cycle 2, `pwdata_hi` = 0xDEADBEEF; `o_valid` in cycle 3 with `o_resp` = 00 and `o_data` = 0.
- Read with 3 wait states.
  - Stimulus: `prdata_hi` = 0x12345678.
  - Required: `penable_hi` high for 4 cycles; `o_data` = 0x12345678; `o_valid` in cycle 6.
- Slave error and timeout, `TIMEOUT` = 4.
  - `pslverr_hi` = 1 with `pready_hi`: `o_resp` = 10.
  - `pready_hi` held 0: `o_resp` = 11 after 4 ACCESS cycles, with `psel_hi` = 0 in the RESP cycle.
- Misaligned request: `i_addr` = 0x2.
  - Required: `psel_hi` never asserts; `o_resp` = 01 in the next cycle.
- Response backpressure: `i_ready` = 0 for 5 cycles while `i_valid` is held high with a second request.
  - Required: `o_ready` = 0 and `o_data`/`o_resp` stable throughout.
  - The second request is accepted in the cycle after the response handshake.
- Reset during ACCESS with `pready_hi` = 0.
  - Required: all outputs 0 at the next edge; no `o_valid` afterwards.
  - A following request completes normally.

Source files
------------

// File: rtl/vr_apb_bridge.sv
// vr_apb_bridge: turns a valid/ready request stream into single APB
// transfers and returns one registered response per request. Misaligned
// requests are answered locally, and a stalled completer is cut off by an
// access timeout.
module vr_apb_bridge #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic          i_write,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [DW-1:0] o_data,
  output logic [1:0]    o_resp,
  output logic          psel_hi,
  output logic          penable_hi,
  output logic          pwrite_hi,
  output logic [AW-1:0] paddr_hi,
  output logic [DW-1:0] pwdata_hi,
  input  logic [DW-1:0] prdata_hi,
  input  logic          pready_hi,
  input  logic          pslverr_hi
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic [1:0] RESP_OK       = 2'b00;
  localparam logic [1:0] RESP_MISALIGN = 2'b01;
  localparam logic [1:0] RESP_SLVERR   = 2'b10;
  localparam logic [1:0] RESP_TIMEOUT  = 2'b11;

  // A zero TIMEOUT disables the counter; keep it one bit wide so it still exists.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // The counter value seen in the last ACCESS cycle allowed before timing out.
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  logic [1:0]    state;
  logic [CW-1:0] wait_cnt;
  logic          accept;
  logic          misaligned;
  logic          tmo_hit;
  logic          apb_done;

  // Saturating increment: the wait counter must never wrap back to zero.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  assign o_ready    = (state == S_IDLE) && !i_rst;
  assign accept     = i_valid && o_ready;
  assign misaligned = (i_addr[1:0] != 2'b00);
  // pready_hi wins over a timeout landing in the same cycle.
  assign tmo_hit    = (TIMEOUT != 0) && (state == S_ACCESS) && !pready_hi &&
                      (wait_cnt == CNT_LAST);
  assign apb_done   = (state == S_ACCESS) && (pready_hi || tmo_hit);

  // Control FSM, wait counter and the registered response.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      o_valid  <= 1'b0;
      o_data   <= '0;
      o_resp   <= RESP_OK;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (misaligned) begin
              o_valid <= 1'b1;
              o_data  <= '0;
              o_resp  <= RESP_MISALIGN;
              state   <= S_RESP;
            end else begin
              state <= S_SETUP;
            end
          end
        end
        S_SETUP: begin
          wait_cnt <= '0;
          state    <= S_ACCESS;
        end
        S_ACCESS: begin
          if (pready_hi) begin
            // Read data is only meaningful on a clean read; errors return zero.
            o_data  <= (!pwrite_hi && !pslverr_hi) ? prdata_hi : '0;
            o_resp  <= pslverr_hi ? RESP_SLVERR : RESP_OK;
            o_valid <= 1'b1;
            state   <= S_RESP;
          end else if (tmo_hit) begin
            o_data  <= '0;
            o_resp  <= RESP_TIMEOUT;
            o_valid <= 1'b1;
            state   <= S_RESP;
          end else begin
            wait_cnt <= sat_inc(wait_cnt);
          end
        end
        S_RESP: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_resp  <= RESP_OK;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // APB bus registers: loaded on an aligned accept, dropped when the transfer ends.
  always_ff @(posedge i_clk) begin
    if (i_rst || apb_done) begin
      psel_hi    <= 1'b0;
      penable_hi <= 1'b0;
      pwrite_hi  <= 1'b0;
      paddr_hi   <= '0;
      pwdata_hi  <= '0;
    end else if (accept && !misaligned) begin
      psel_hi    <= 1'b1;
      penable_hi <= 1'b0;
      pwrite_hi  <= i_write;
      paddr_hi   <= i_addr;
      pwdata_hi  <= i_wdata;
    end else if (state == S_SETUP) begin
      penable_hi <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vr_apb_bridge.sv
// Testbench for vr_apb_bridge: each transaction is described by its
// parameters, the per-cycle expected outputs are derived from the bridge's
// timing rules, and every cycle is compared at mid-period.
module tb_vr_apb_bridge;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic          i_clk, i_rst, i_valid, o_ready, i_write;
  logic [AW-1:0] i_addr, paddr_hi;
  logic [DW-1:0] i_wdata, o_data, pwdata_hi, prdata_hi;
  logic          o_valid, i_ready, psel_hi, penable_hi, pwrite_hi;
  logic          pready_hi, pslverr_hi;
  logic [1:0]    o_resp;

  vr_apb_bridge #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_resp(o_resp),
    .psel_hi(psel_hi), .penable_hi(penable_hi), .pwrite_hi(pwrite_hi),
    .paddr_hi(paddr_hi), .pwdata_hi(pwdata_hi), .prdata_hi(prdata_hi),
    .pready_hi(pready_hi), .pslverr_hi(pslverr_hi)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic          ready, valid, psel, pen, chk_bus, chk_rsp, pwrite;
    logic [1:0]    resp;
    logic [DW-1:0] data, pwdata;
    logic [AW-1:0] paddr;
  } exp_t;

  int checks = 0, errors = 0, cyc = 0, pen_cnt = 0, psel_cnt = 0;
  logic          obs_valid;
  logic [DW-1:0] obs_data;
  logic [1:0]    obs_resp;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t e_zero();
    exp_t e;
    e = '{default: '0};
    e.chk_bus = 1'b1;
    e.chk_rsp = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_idle();
    exp_t e;
    e = e_zero();
    e.ready = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_bus(input logic wr, input logic [AW-1:0] a,
                                 input logic [DW-1:0] wd, input logic pen);
    exp_t e;
    e = '{default: '0};
    e.psel = 1'b1; e.pen = pen; e.chk_bus = 1'b1;
    e.pwrite = wr; e.paddr = a; e.pwdata = wd;
    return e;
  endfunction

  function automatic exp_t e_resp(input logic [1:0] code, input logic [DW-1:0] d);
    exp_t e;
    e = '{default: '0};
    e.valid = 1'b1; e.chk_rsp = 1'b1; e.resp = code; e.data = d;
    return e;
  endfunction

  // Called just after a falling edge with this cycle's inputs already driven.
  task automatic tick(input exp_t e);
    #1;
    chk("o_ready", o_ready, e.ready);
    chk("o_valid", o_valid, e.valid);
    chk("psel_hi", psel_hi, e.psel);
    chk("penable_hi", penable_hi, e.pen);
    if (e.chk_rsp) begin
      chk("o_data", o_data, e.data);
      chk("o_resp", o_resp, e.resp);
    end
    if (e.chk_bus) begin
      chk("pwrite_hi", pwrite_hi, e.pwrite);
      chk("paddr_hi", paddr_hi, e.paddr);
      chk("pwdata_hi", pwdata_hi, e.pwdata);
    end
    obs_valid = o_valid; obs_data = o_data; obs_resp = o_resp;
    if (penable_hi === 1'b1) pen_cnt++;
    if (psel_hi === 1'b1) psel_cnt++;
    cyc++;
    @(negedge i_clk);
  endtask

  task automatic rand_apb();
    pready_hi  = 1'($urandom);
    pslverr_hi = 1'($urandom);
    prdata_hi  = $urandom;
  endtask

  // Inputs while the bridge is busy: request side is ignored, so it is either
  // noise or a held follow-on request.
  task automatic drive_busy(input logic hold, input logic h_wr,
                            input logic [AW-1:0] h_addr, input logic [DW-1:0] h_wd);
    if (hold) begin
      i_valid = 1'b1; i_write = h_wr; i_addr = h_addr; i_wdata = h_wd;
    end else begin
      i_valid = 1'($urandom); i_write = 1'($urandom);
      i_addr = $urandom; i_wdata = $urandom;
    end
    i_ready = 1'($urandom);
  endtask

  task automatic idle_tick();
    i_valid = 1'b0; i_write = 1'($urandom); i_addr = $urandom; i_wdata = $urandom;
    i_ready = 1'($urandom);
    rand_apb();
    tick(e_idle());
  endtask

  // One request from accept to response handshake. lat is the number of
  // cycles from the accept cycle to the first cycle with o_valid high.
  task automatic do_txn(input logic wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                        input int waits, input logic serr, input int bp,
                        input logic hold, input logic h_wr,
                        input logic [AW-1:0] h_addr, input logic [DW-1:0] h_wd,
                        output int lat, output int pens, output int psels,
                        output logic [DW-1:0] r_data, output logic [1:0] r_resp);
    logic          aligned, tmo;
    int            n_acc, n;
    logic [1:0]    ecode;
    logic [DW-1:0] edata;
    aligned = (addr[1:0] == 2'b00);
    pen_cnt = 0; psel_cnt = 0; lat = -1; n = 0;
    r_data = '0; r_resp = '0;
    i_valid = 1'b1; i_write = wr; i_addr = addr; i_wdata = wd;
    i_ready = 1'($urandom);
    rand_apb();
    tick(e_idle());
    if (aligned) begin
      tmo   = (waits >= TMO);
      n_acc = tmo ? TMO : waits + 1;
      ecode = tmo ? 2'b11 : (serr ? 2'b10 : 2'b00);
      edata = (tmo || serr || wr) ? '0 : rd;
      drive_busy(hold, h_wr, h_addr, h_wd);
      rand_apb();
      tick(e_bus(wr, addr, wd, 1'b0));
      n++;
      for (int k = 0; k < n_acc; k++) begin
        drive_busy(hold, h_wr, h_addr, h_wd);
        if (!tmo && k == waits) begin
          pready_hi = 1'b1; pslverr_hi = serr; prdata_hi = rd;
        end else begin
          pready_hi = 1'b0; pslverr_hi = 1'($urandom); prdata_hi = $urandom;
        end
        tick(e_bus(wr, addr, wd, 1'b1));
        n++;
      end
    end else begin
      ecode = 2'b01;
      edata = '0;
    end
    for (int j = 0; j <= bp; j++) begin
      drive_busy(hold, h_wr, h_addr, h_wd);
      i_ready = (j == bp);
      rand_apb();
      tick(e_resp(ecode, edata));
      if (obs_valid === 1'b1 && lat < 0) begin
        lat = n + 1; r_data = obs_data; r_resp = obs_resp;
      end
      n++;
    end
    pens = pen_cnt; psels = psel_cnt;
  endtask

  initial begin
    int            lat, pens, psels;
    logic [DW-1:0] d;
    logic [1:0]    r;
    logic          wr;
    logic [AW-1:0] a;

    i_rst = 1'b1; i_valid = 1'b0; i_write = 1'b0; i_addr = '0; i_wdata = '0;
    i_ready = 1'b0; pready_hi = 1'b0; pslverr_hi = 1'b0; prdata_hi = '0;
    @(negedge i_clk);
    repeat (2) tick(e_zero());
    i_rst = 1'b0;
    repeat (2) idle_tick();

    // Zero-wait write
    do_txn(1'b1, 32'h1000_0004, 32'hDEADBEEF, 32'h0, 0, 1'b0, 0, 1'b0, 1'b0, '0, '0,
           lat, pens, psels, d, r);
    chk("wr0_latency", lat, 3);
    chk("wr0_resp", r, 2'b00);
    chk("wr0_data", d, 32'h0);
    chk("wr0_penable_cycles", pens, 1);

    // Read with three wait states
    do_txn(1'b0, 32'h0000_0040, 32'h0, 32'h12345678, 3, 1'b0, 0, 1'b0, 1'b0, '0, '0,
           lat, pens, psels, d, r);
    chk("rd3_latency", lat, 6);
    chk("rd3_penable_cycles", pens, 4);
    chk("rd3_data", d, 32'h12345678);
    chk("rd3_resp", r, 2'b00);

    // Slave error
    do_txn(1'b0, 32'h0000_0080, 32'h0, 32'hCAFEF00D, 1, 1'b1, 1, 1'b0, 1'b0, '0, '0,
           lat, pens, psels, d, r);
    chk("slverr_resp", r, 2'b10);
    chk("slverr_latency", lat, 4);

    // Timeout: completer never ready
    do_txn(1'b1, 32'h0000_00C0, 32'h55AA55AA, 32'h0, 20, 1'b0, 0, 1'b0, 1'b0, '0, '0,
           lat, pens, psels, d, r);
    chk("tmo_resp", r, 2'b11);
    chk("tmo_latency", lat, 6);
    chk("tmo_penable_cycles", pens, 4);
    chk("tmo_data", d, 32'h0);

    // Misaligned request
    do_txn(1'b0, 32'h0000_0002, 32'h0, 32'h0, 0, 1'b0, 0, 1'b0, 1'b0, '0, '0,
           lat, pens, psels, d, r);
    chk("mis_latency", lat, 1);
    chk("mis_resp", r, 2'b01);
    chk("mis_psel_cycles", psels, 0);

    // Backpressure with a second request held on the input
    do_txn(1'b0, 32'h0000_0100, 32'h0, 32'hA5A5_0001, 0, 1'b0, 5, 1'b1,
           1'b1, 32'h0000_0200, 32'h0BAD_F00D, lat, pens, psels, d, r);
    chk("bp_data", d, 32'hA5A5_0001);
    do_txn(1'b1, 32'h0000_0200, 32'h0BAD_F00D, 32'h0, 0, 1'b0, 0, 1'b0, 1'b0, '0, '0,
           lat, pens, psels, d, r);
    chk("bp_second_latency", lat, 3);

    // Reset during ACCESS with the completer stalled
    i_valid = 1'b1; i_write = 1'b0; i_addr = 32'h0000_0300; i_wdata = '0;
    i_ready = 1'b0; pready_hi = 1'b0;
    tick(e_idle());
    i_valid = 1'b0; pready_hi = 1'b0;
    tick(e_bus(1'b0, 32'h0000_0300, 32'h0, 1'b0));
    pready_hi = 1'b0;
    tick(e_bus(1'b0, 32'h0000_0300, 32'h0, 1'b1));
    i_rst = 1'b1; pready_hi = 1'b0;
    tick(e_bus(1'b0, 32'h0000_0300, 32'h0, 1'b1));
    tick(e_zero());
    i_rst = 1'b0;
    repeat (3) idle_tick();
    do_txn(1'b0, 32'h0000_0304, 32'h0, 32'h7777_8888, 2, 1'b0, 0, 1'b0, 1'b0, '0, '0,
           lat, pens, psels, d, r);
    chk("post_rst_data", d, 32'h7777_8888);
    chk("post_rst_latency", lat, 5);

    // Randomized traffic
    for (int t = 0; t < 80; t++) begin
      wr = 1'($urandom);
      a  = $urandom;
      if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
      do_txn(wr, a, $urandom, $urandom, $urandom_range(0, 6), 1'($urandom),
             $urandom_range(0, 3), 1'b0, 1'b0, '0, '0, lat, pens, psels, d, r);
      repeat ($urandom_range(0, 2)) idle_tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
